// File: rtl/keypad_scanner_if.sv
// Scanner-to-board signal bundle: matrix strobes/returns plus the debounced
// digit outputs consumed by the microwave controller.
interface keypad_scanner_if;
   logic [3:0] row_n;
   logic [2:0] col_n;
   logic [9:0] keypad;
   logic       key_pulse;

   modport master (
      input  row_n,
      output col_n,
      output keypad,
      output key_pulse
   );

   modport slave (
      output row_n,
      input  col_n,
      input  keypad,
      input  key_pulse
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column strobing, row synchronisation,
// full-frame debounce and a one-hot held digit with a new-digit strobe.
module keypad_scanner #(
   parameter int unsigned COL_DWELL      = 1000,
   parameter int unsigned DEBOUNCE_SCANS = 4
) (
   input  logic             clk,
   input  logic             resetn,
   keypad_scanner_if.master kp
);

   localparam int unsigned CNT_W = (COL_DWELL > 1) ? $clog2(COL_DWELL) : 1;
   localparam int unsigned STB_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
   localparam logic [3:0]  NONE  = 4'hF;

   typedef enum logic [2:0] {
      COL0 = 3'b110,
      COL1 = 3'b101,
      COL2 = 3'b011
   } col_t;

   col_t             col;
   logic [CNT_W-1:0] dwell;
   logic [3:0]       row_meta;
   logic [3:0]       row_sync;
   logic [2:0][3:0]  image;
   logic             frame_done;
   logic [3:0]       hits;
   logic [3:0]       cand;
   logic [3:0]       prev_cand;
   logic [STB_W-1:0] stable;
   logic [STB_W-1:0] next_stable;
   logic [9:0]       new_keypad;
   logic [9:0]       keypad_q;
   logic             pulse_q;

   function automatic logic [3:0] key_code(input int unsigned r, input int unsigned c);
      if (r < 3)
         return 4'(r * 3 + c + 1);
      else if (c == 1)
         return 4'd0;
      else
         return NONE;
   endfunction

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         row_meta <= '1;
         row_sync <= '1;
      end else begin
         row_meta <= kp.row_n;
         row_sync <= row_meta;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         col        <= COL0;
         dwell      <= '0;
         image      <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (dwell == CNT_W'(COL_DWELL - 1)) begin
            dwell <= '0;
            case (col)
               COL0: begin
                  image[0] <= ~row_sync;
                  col      <= COL1;
               end
               COL1: begin
                  image[1] <= ~row_sync;
                  col      <= COL2;
               end
               COL2: begin
                  image[2]   <= ~row_sync;
                  col        <= COL0;
                  frame_done <= 1'b1;
               end
               default: col <= COL0;
            endcase
         end else begin
            dwell <= dwell + CNT_W'(1);
         end
      end
   end

   // Any count other than exactly one key (ghosting, rollover, idle) is "none".
   always_comb begin
      hits = '0;
      cand = NONE;
      for (int unsigned r = 0; r < 4; r++) begin
         for (int unsigned c = 0; c < 3; c++) begin
            if (image[c][r]) begin
               hits = hits + 4'd1;
               cand = key_code(r, c);
            end
         end
      end
      if (hits != 4'd1)
         cand = NONE;
   end

   always_comb begin
      if (cand != prev_cand)
         next_stable = STB_W'(1);
      else if (stable == STB_W'(DEBOUNCE_SCANS))
         next_stable = stable;
      else
         next_stable = stable + STB_W'(1);
      new_keypad = (cand == NONE) ? '0 : (10'd1 << cand);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prev_cand <= NONE;
         stable    <= '0;
         keypad_q  <= '0;
         pulse_q   <= 1'b0;
      end else begin
         pulse_q <= 1'b0;
         if (frame_done) begin
            prev_cand <= cand;
            stable    <= next_stable;
            if (next_stable == STB_W'(DEBOUNCE_SCANS)) begin
               keypad_q <= new_keypad;
               pulse_q  <= (new_keypad != '0) && (new_keypad != keypad_q);
            end
         end
      end
   end

   assign kp.col_n     = col;
   assign kp.keypad    = keypad_q;
   assign kp.key_pulse = pulse_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised frame-level check of keypad_scanner against a history-queue
// debounce model (COL_DWELL=4, DEBOUNCE_SCANS=3, 12-cycle frames).
module tb_keypad_scanner;

   localparam int DWELL = 4;
   localparam int DEB   = 3;

   logic        clk;
   logic        resetn;
   logic [11:0] keys;   // bit r*3+c = key at (row r, col c) held down

   int n_total;
   int n_bad;

   int         hist[$];
   logic [9:0] exp_kp;
   bit         exp_pulse;

   keypad_scanner_if ifc ();

   keypad_scanner #(
      .COL_DWELL      (DWELL),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .kp     (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive matrix: a row reads low when a held key sits on the strobed column.
   always_comb begin
      ifc.row_n = '1;
      for (int r = 0; r < 4; r++)
         ifc.row_n[r] = ~|(keys[r*3 +: 3] & ~ifc.col_n);
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int frame_cand(input logic [11:0] k);
      if ($countones(k) != 1) return -1;
      for (int i = 0; i < 12; i++)
         if (k[i]) begin
            if (i < 9) return i + 1;
            if (i == 10) return 0;
            return -1;
         end
      return -1;
   endfunction

   task automatic model_reset();
      hist.delete();
      exp_kp    = '0;
      exp_pulse = 1'b0;
   endtask

   task automatic model_frame(input logic [11:0] k);
      int         c;
      bit         same;
      logic [9:0] nv;
      c = frame_cand(k);
      hist.push_back(c);
      if (hist.size() > DEB) void'(hist.pop_front());
      same = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] != c) same = 1'b0;
      exp_pulse = 1'b0;
      if (same) begin
         nv = (c < 0) ? 10'd0 : (10'd1 << c);
         exp_pulse = (nv != 10'd0) && (nv != exp_kp);
         exp_kp = nv;
      end
   endtask

   // Entered at a negedge just after a frame boundary (or reset release).
   task automatic run_frame(input logic [11:0] k, input int ncyc);
      logic [2:0] exp_col;
      keys = k;
      for (int cyc = 0; cyc < ncyc; cyc++) begin
         @(negedge clk);
         case (((cyc + 1) / DWELL) % 3)
            0:       exp_col = 3'b110;
            1:       exp_col = 3'b101;
            default: exp_col = 3'b011;
         endcase
         check("col_n", ifc.col_n, exp_col);
         check("keypad", ifc.keypad, exp_kp);
         check("key_pulse", ifc.key_pulse, (cyc == 0) ? exp_pulse : 1'b0);
         check("onehot", ($countones(ifc.keypad) <= 1), 1);
      end
      if (ncyc == 3 * DWELL) model_frame(k);
   endtask

   task automatic hold(input logic [11:0] k, input int frames);
      for (int f = 0; f < frames; f++) run_frame(k, 3 * DWELL);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #1;
      check("rst_col_n", ifc.col_n, 3'b110);
      check("rst_keypad", ifc.keypad, 0);
      check("rst_key_pulse", ifc.key_pulse, 0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      model_reset();
   endtask

   function automatic logic [11:0] key_bit(input int idx);
      logic [11:0] one;
      one = 12'd1;
      return one << idx;
   endfunction

   initial begin
      int          kind;
      int          a;
      int          b;
      logic [11:0] k;
      n_total = 0;
      n_bad   = 0;
      keys    = '0;
      resetn  = 1'b0;
      model_reset();
      @(negedge clk);
      do_reset();

      hold('0, 4);
      run_frame('0, 5);
      do_reset();
      hold('0, 3);

      hold(key_bit(2), 4);                      // digit 3
      hold('0, 4);

      hold(key_bit(4), 2);                      // digit 5 with a bounce
      hold('0, 1);
      hold(key_bit(4), 4);
      hold('0, 4);

      hold(key_bit(0) | key_bit(8), 4);         // 1 and 9 together
      hold(key_bit(9), 4);                      // *
      hold(key_bit(10), 4);                     // 0
      hold(key_bit(11), 4);                     // #
      hold(key_bit(1), 4);                      // 2 then straight to 8
      hold(key_bit(7), 4);
      hold('0, 4);

      hold(key_bit(8), 20);                     // long 9, reset during hold
      run_frame(key_bit(8), 7);
      do_reset();
      hold(key_bit(8), 5);
      hold('0, 4);

      for (int s = 0; s < 60; s++) begin
         kind = $urandom_range(0, 5);
         a    = $urandom_range(0, 11);
         b    = (a + 1 + $urandom_range(0, 10)) % 12;
         case (kind)
            0:       k = '0;
            4:       k = key_bit(a) | key_bit(b);
            5:       k = key_bit($urandom_range(0, 8));
            default: k = key_bit(a);
         endcase
         if ($urandom_range(0, 14) == 0) begin
            run_frame(k, $urandom_range(1, 11));
            do_reset();
         end
         hold(k, $urandom_range(1, 5));
      end
      hold('0, 4);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
